// File: rtl/reg_dump_streamer.sv
// Register-file dump streamer.
// Reads every debug address once per frame and sends the values as a byte stream:
// HEADER, {hi, lo} per register (address 0 first), then the XOR of every byte before it.
module reg_dump_streamer #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 16,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic              regi_clk,
    input  logic              regi_rst,
    input  logic              dmpi_start,
    output logic [ADDR_W-1:0] dmpo_dbg_addr,
    input  logic [DATA_W-1:0] dmpi_dbg_data,
    output logic [7:0]        dmpo_byte,
    output logic              dmpo_valid,
    input  logic              dmpi_ready,
    output logic              dmpo_busy,
    output logic              dmpo_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CAP,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          byte_q, byte_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs_c;

    // Byte leaves the block on this edge.
    assign hs_c = valid_q & dmpi_ready;

    // State register.
    always_ff @(posedge regi_clk or negedge regi_rst) begin
        if (!regi_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: streaming states advance only when their byte is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (dmpi_start) state_d = S_HDR;
            S_HDR:  if (hs_c) state_d = S_CAP;
            S_CAP:  state_d = S_HI;
            S_HI:   if (hs_c) state_d = S_LO;
            S_LO:   if (hs_c) state_d = (idx_q == LAST_IDX) ? S_CSUM : S_CAP;
            S_CSUM: if (hs_c) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates and registered output values, aligned with the next state.
    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        csum_d   = csum_q;
        byte_d   = byte_q;

        case (state_q)
            S_IDLE: begin
                if (dmpi_start) begin
                    idx_d  = '0;
                    csum_d = '0;
                end
            end
            S_HDR:  if (hs_c) csum_d = csum_q ^ HEADER;
            S_CAP:  shadow_d = dmpi_dbg_data;
            S_HI:   if (hs_c) csum_d = csum_q ^ byte_q;
            S_LO: begin
                if (hs_c) begin
                    csum_d = csum_q ^ byte_q;
                    if (idx_q != LAST_IDX) idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase

        // A stalled state recomputes the same byte, so byte/valid hold while not accepted.
        case (state_d)
            S_HDR:  byte_d = HEADER;
            S_HI:   byte_d = shadow_d[DATA_W-1 -: 8];
            S_LO:   byte_d = shadow_d[7:0];
            S_CSUM: byte_d = csum_d;
            default: ;
        endcase

        valid_d = (state_d == S_HDR) || (state_d == S_HI) ||
                  (state_d == S_LO)  || (state_d == S_CSUM);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge regi_clk or negedge regi_rst) begin
        if (!regi_rst) begin
            idx_q    <= '0;
            shadow_q <= '0;
            csum_q   <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            csum_q   <= csum_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dmpo_dbg_addr = idx_q;
    assign dmpo_byte     = byte_q;
    assign dmpo_valid    = valid_q;
    assign dmpo_busy     = busy_q;
    assign dmpo_done     = done_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer: a frame model built from the register
// contents, driven with fixed, stalled and random ready patterns.
module tb_reg_dump_streamer;

    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned FRAME_LEN = 2 * NUM_REGS + 2;
    localparam int unsigned SPAN      = 3 * NUM_REGS + 4;

    logic        regi_clk = 1'b0;
    logic        regi_rst = 1'b0;
    logic        dmpi_start = 1'b0;
    logic        dmpi_ready = 1'b0;
    logic [3:0]  dmpo_dbg_addr;
    logic [15:0] dmpi_dbg_data;
    logic [7:0]  dmpo_byte;
    logic        dmpo_valid;
    logic        dmpo_busy;
    logic        dmpo_done;

    logic [15:0] regs [NUM_REGS];

    int errors = 0;
    int checks = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int  done_cnt, busy_cnt, span, stall_viol, stall_cycles;
    bit  timed_out;

    reg_dump_streamer dut (
        .regi_clk      (regi_clk),
        .regi_rst      (regi_rst),
        .dmpi_start    (dmpi_start),
        .dmpo_dbg_addr (dmpo_dbg_addr),
        .dmpi_dbg_data (dmpi_dbg_data),
        .dmpo_byte     (dmpo_byte),
        .dmpo_valid    (dmpo_valid),
        .dmpi_ready    (dmpi_ready),
        .dmpo_busy     (dmpo_busy),
        .dmpo_done     (dmpo_done)
    );

    always #5 regi_clk = ~regi_clk;

    // Register file debug port: combinational read.
    always_comb dmpi_dbg_data = regs[dmpo_dbg_addr];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_ramp();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'(i);
    endtask

    // Expected frame from current register contents.
    task automatic build_expected();
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'hA5;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back(regs[i][15:8]);
            exp_q.push_back(regs[i][7:0]);
            x = x ^ regs[i][15:8] ^ regs[i][7:0];
        end
        exp_q.push_back(x);
    endtask

    // Pulse start and collect one frame. mode 0: ready=1, 1: random, 2: 5-cycle stall on byte 3.
    // wr_at >= 0: write r2=BEEF when byte number wr_at is first presented.
    task automatic run_frame(input int mode, input bit start_all, input int wr_at);
        logic       pv, pr;
        logic [7:0] pb;
        bit         wrote;
        got.delete();
        done_cnt = 0; busy_cnt = 0; stall_viol = 0; stall_cycles = 0;
        timed_out = 1; wrote = 0; pv = 0; pr = 0; pb = '0;
        @(negedge regi_clk);
        dmpi_start = 1'b1;
        dmpi_ready = 1'b0;
        span = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge regi_clk);
            span++;
            if (!start_all) dmpi_start = 1'b0;
            if (pv && !pr && (dmpo_valid !== 1'b1 || dmpo_byte !== pb)) stall_viol++;
            if (dmpo_busy === 1'b1) busy_cnt++;
            if (dmpo_done === 1'b1) done_cnt++;
            if (wr_at >= 0 && !wrote && dmpo_valid && got.size() == wr_at) begin
                regs[2] = 16'hBEEF;
                wrote = 1;
            end
            case (mode)
                0: dmpi_ready = 1'b1;
                1: dmpi_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (dmpo_valid && got.size() == 3 && stall_cycles < 5) begin
                        dmpi_ready = 1'b0;
                        stall_cycles++;
                    end else begin
                        dmpi_ready = 1'b1;
                    end
                end
            endcase
            if (dmpo_valid && dmpi_ready) got.push_back(dmpo_byte);
            pv = dmpo_valid; pr = dmpi_ready; pb = dmpo_byte;
            if (dmpo_done === 1'b1) begin
                timed_out = 0;
                break;
            end
        end
        dmpi_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge regi_clk);
        checks++; if (dmpo_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", dmpo_valid); end
        checks++; if (dmpo_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", dmpo_busy); end
        checks++; if (dmpo_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", dmpo_done); end
        checks++; if (dmpo_byte !== 8'h00) begin errors++; $display("FAIL rst_byte got=%h exp=00", dmpo_byte); end
        checks++; if (dmpo_dbg_addr !== 4'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", dmpo_dbg_addr); end
        regi_rst = 1'b1;
        @(negedge regi_clk);
    endtask

    task automatic test_basic_frame();
        set_ramp();
        build_expected();
        run_frame(0, 1'b0, -1);
        dmpi_start = 1'b0;
        checks++; if (timed_out) begin errors++; $display("FAIL t1_timeout got=no_done exp=done"); end
        checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t1_len got=%0d exp=%0d", got.size(), FRAME_LEN); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t1_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL t1_done_cnt got=%0d exp=1", done_cnt); end
        // Span counts the start cycle through the done cycle; busy rises on the start edge.
        checks++; if (span != SPAN) begin errors++; $display("FAIL t1_span got=%0d exp=%0d", span, SPAN); end
        checks++; if (busy_cnt != SPAN - 1) begin errors++; $display("FAIL t1_busy_cycles got=%0d exp=%0d", busy_cnt, SPAN - 1); end
        @(negedge regi_clk);
        checks++; if (dmpo_done !== 1'b0) begin errors++; $display("FAIL t1_done_width got=%b exp=0", dmpo_done); end
        checks++; if (dmpo_busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end got=%b exp=0", dmpo_busy); end
    endtask

    task automatic test_backpressure();
        set_ramp();
        build_expected();
        run_frame(2, 1'b0, -1);
        dmpi_start = 1'b0;
        checks++; if (timed_out) begin errors++; $display("FAIL t2_timeout got=no_done exp=done"); end
        checks++; if (stall_cycles != 5) begin errors++; $display("FAIL t2_stall_applied got=%0d exp=5", stall_cycles); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL t2_hold got=%0d exp=0 violations", stall_viol); end
        checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t2_len got=%0d exp=%0d", got.size(), FRAME_LEN); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t2_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++; if (span != SPAN + 5) begin errors++; $display("FAIL t2_span got=%0d exp=%0d", span, SPAN + 5); end
    endtask

    task automatic test_start_spam();
        int extra_valid, extra_done, extra_busy;
        set_ramp();
        build_expected();
        run_frame(0, 1'b1, -1);
        @(negedge regi_clk);
        dmpi_start = 1'b0;
        extra_valid = 0; extra_done = 0; extra_busy = 0;
        for (int c = 0; c < 6; c++) begin
            if (dmpo_valid === 1'b1) extra_valid++;
            if (dmpo_done === 1'b1) extra_done++;
            if (dmpo_busy === 1'b1) extra_busy++;
            @(negedge regi_clk);
        end
        checks++; if (timed_out) begin errors++; $display("FAIL t3_timeout got=no_done exp=done"); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL t3_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t3_len got=%0d exp=%0d", got.size(), FRAME_LEN); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t3_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++; if (extra_valid + extra_done + extra_busy != 0) begin
            errors++; $display("FAIL t3_restart got=valid%0d/done%0d/busy%0d exp=0/0/0", extra_valid, extra_done, extra_busy);
        end
    endtask

    task automatic test_midframe_reset();
        int  n;
        bit  hit;
        set_ramp();
        build_expected();
        n = 0; hit = 0;
        @(negedge regi_clk);
        dmpi_start = 1'b1;
        dmpi_ready = 1'b1;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge regi_clk);
            dmpi_start = 1'b0;
            if (dmpo_valid && n == 10) begin
                regi_rst = 1'b0;
                #1;
                hit = 1;
            end else if (dmpo_valid) begin
                n++;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL t4_reach_byte10 got=%0d exp=10", n); end
        checks++; if (dmpo_valid !== 1'b0) begin errors++; $display("FAIL t4_valid got=%b exp=0", dmpo_valid); end
        checks++; if (dmpo_busy !== 1'b0) begin errors++; $display("FAIL t4_busy got=%b exp=0", dmpo_busy); end
        dmpi_ready = 1'b0;
        @(negedge regi_clk);
        regi_rst = 1'b1;
        run_frame(0, 1'b0, -1);
        dmpi_start = 1'b0;
        checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t4_len got=%0d exp=%0d", got.size(), FRAME_LEN); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t4_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_consistency();
        // Write before r2 is captured: new value appears in the frame.
        set_ramp();
        regs[2] = 16'hBEEF;
        build_expected();
        run_frame(0, 1'b0, -1);
        dmpi_start = 1'b0;
        checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t5a_len got=%0d exp=%0d", got.size(), FRAME_LEN); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t5a_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        // Write once r2's high byte is on the bus (already captured): old value reported.
        set_ramp();
        build_expected();
        run_frame(0, 1'b0, 5);
        dmpi_start = 1'b0;
        checks++; if (regs[2] !== 16'hBEEF) begin errors++; $display("FAIL t5b_write_done got=%h exp=beef", regs[2]); end
        checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t5b_len got=%0d exp=%0d", got.size(), FRAME_LEN); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t5b_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'($urandom);
            build_expected();
            run_frame(1, 1'b0, -1);
            dmpi_start = 1'b0;
            checks++; if (timed_out || done_cnt != 1) begin errors++; $display("FAIL t6_done[%0d] got=%0d exp=1", f, done_cnt); end
            checks++; if (stall_viol != 0) begin errors++; $display("FAIL t6_hold[%0d] got=%0d exp=0", f, stall_viol); end
            checks++; if (got.size() != FRAME_LEN) begin errors++; $display("FAIL t6_len[%0d] got=%0d exp=%0d", f, got.size(), FRAME_LEN); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t6_byte[%0d][%0d] got=%h exp=%h", f, i, got[i], exp_q[i]); end
            end
            repeat (2) @(negedge regi_clk);
        end
    endtask

    initial begin
        set_ramp();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_start_spam();
        test_midframe_reset();
        test_consistency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
